// File: rtl/fpu_arb_pkg.sv
// Shared types and limits for the shared-FPU round-robin arbiter.
package fpu_arb_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned LAT_MAX  = 16;

    typedef logic [FP_W-1:0] fp32_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } tag_t;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } lock_st_e;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester and shared-FPU signal bundle for fpu_arbiter.
// The lock vector exists only when FPU_ARB_LOCK_EN is defined.
interface fpu_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import fpu_arb_pkg::*;

    logic [NREQ-1:0] req;
    fp32_t           op_a [NREQ];
    fp32_t           op_b [NREQ];
    logic [NREQ-1:0] gnt;
    fp32_t           fpu_a;
    fp32_t           fpu_b;
    fp32_t           fpu_q;
    logic [NREQ-1:0] rsp_valid;
    fp32_t           rsp_data;
`ifdef FPU_ARB_LOCK_EN
    logic [NREQ-1:0] lock;

    modport master (
        output req, op_a, op_b, lock, fpu_q,
        input  gnt, fpu_a, fpu_b, rsp_valid, rsp_data
    );
    modport slave (
        input  req, op_a, op_b, lock, fpu_q,
        output gnt, fpu_a, fpu_b, rsp_valid, rsp_data
    );
`else
    modport master (
        output req, op_a, op_b, fpu_q,
        input  gnt, fpu_a, fpu_b, rsp_valid, rsp_data
    );
    modport slave (
        input  req, op_a, op_b, fpu_q,
        output gnt, fpu_a, fpu_b, rsp_valid, rsp_data
    );
`endif

endinterface

// File: rtl/fpu_tag_pipe.sv
// LAT-deep {valid, idx} shift register tracking operations inside the shared FPU.
// Flush clears every valid bit at the next edge; reset clears asynchronously.
module fpu_tag_pipe
    import fpu_arb_pkg::*;
#(
    parameter int unsigned LAT = 5
) (
    input  logic clk,
    input  logic areset_n,
    input  logic flush,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic busy
);

    tag_t stage_q [LAT];

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

    assign tag_out = stage_q[LAT-1];

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP unit among NREQ requesters.
// Define FPU_ARB_LOCK_EN to add the per-requester lock input and IDLE/LOCKED FSM.
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 5
) (
    input  logic                clk,
    input  logic                areset_n,
    input  logic                flush,
    fpu_arbiter_if.slave        bus,
    output logic                busy
);

    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt;
    logic [2:0]      gnt_idx;
    logic            grant_any;
    logic            hold_lock;
    tag_t            issue_tag;
    tag_t            ret_tag;
    logic [NREQ-1:0] rsp_valid;

`ifdef FPU_ARB_LOCK_EN
    lock_st_e   st_q, st_d;
    logic [2:0] lock_idx_q, lock_idx_d;
    logic       lock_cur;
    logic       lock_hit;

    // While the owner keeps lock high, everyone else is masked out.
    always_comb begin
        lock_cur = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == lock_idx_q) lock_cur = bus.lock[i];
        end
        hold_lock = (st_q == StLocked) && lock_cur && !flush;
        eligible  = bus.req;
        if (hold_lock) begin
            for (int i = 0; i < NREQ; i++) begin
                if (3'(i) != lock_idx_q) eligible[i] = 1'b0;
            end
        end
    end

    assign lock_hit = |(gnt & bus.lock);

    always_comb begin
        st_d       = st_q;
        lock_idx_d = lock_idx_q;
        unique case (st_q)
            StIdle: begin
                if (lock_hit) begin
                    st_d       = StLocked;
                    lock_idx_d = gnt_idx;
                end
            end
            StLocked: begin
                if (!hold_lock) begin
                    st_d = lock_hit ? StLocked : StIdle;
                    if (lock_hit) lock_idx_d = gnt_idx;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            st_q       <= StIdle;
            lock_idx_q <= '0;
        end else begin
            st_q       <= st_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    assign hold_lock = 1'b0;
    assign eligible  = bus.req;
`endif

    // Two passes: indices at/after the pointer first, then the wrapped-around ones.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        grant_any = 1'b0;
        if (areset_n && !flush) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any && eligible[i] && (3'(i) >= rr_ptr_q)) begin
                    gnt[i]    = 1'b1;
                    gnt_idx   = 3'(i);
                    grant_any = 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any && eligible[i] && (3'(i) < rr_ptr_q)) begin
                    gnt[i]    = 1'b1;
                    gnt_idx   = 3'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any && !hold_lock) begin
            rr_ptr_d = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign issue_tag = '{valid: grant_any, idx: gnt_idx};

    fpu_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .areset_n (areset_n),
        .flush    (flush),
        .tag_in   (issue_tag),
        .tag_out  (ret_tag),
        .busy     (busy)
    );

    // A result landing in a flush cycle belongs to a discarded operation.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ret_tag.valid && !flush && (ret_tag.idx == 3'(i))) rsp_valid[i] = 1'b1;
        end
    end

    always_comb begin
        bus.fpu_a = '0;
        bus.fpu_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                bus.fpu_a = bus.op_a[i];
                bus.fpu_b = bus.op_b[i];
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = (|rsp_valid) ? bus.fpu_q : '0;

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter LAT, default 5, fixed pipeline latency of the shared FP unit in cycles (1..16).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 areset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous discard of all in-flight operations.
REQ-006 req  input  NREQ  per-requester operation request, level, held until granted.
REQ-007 op_a, op_b  input  NREQ x 32  per-requester IEEE-754 single operands.
REQ-008 gnt  output  NREQ  one-hot-or-zero grant, same cycle as accepted req.
REQ-009 fpu_a, fpu_b  output  32  operands driven to the shared fp_mul/fp_addsub.
REQ-010 fpu_q  input  32  shared unit result, valid LAT cycles after operand issue.
REQ-011 rsp_valid  output  NREQ  one-cycle pulse routing a result to its requester.
REQ-012 rsp_data  output  32  result data, qualified by rsp_valid.
REQ-013 busy  output  1  high while any issued operation is in flight.

Function
REQ-014 At most one gnt bit SHALL be high per cycle; gnt[i] only when req[i] high.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, ascending index with wrap-around NREQ-1 -> 0.
REQ-016 After a grant to index i, rr_ptr SHALL become (i+1) mod NREQ; with no grant rr_ptr SHALL hold.
REQ-017 Grant SHALL be combinational from req and rr_ptr; a granted requester SHALL drop or change its req/op on the following cycle.
REQ-018 fpu_a/fpu_b SHALL equal op_a/op_b of the granted index; 32'h0 when no grant.
REQ-019 A LAT-deep tag pipeline SHALL carry {valid, index} per issue cycle; one issue per cycle sustained (full throughput).
REQ-020 Exactly LAT cycles after gnt[i], rsp_valid[i] SHALL pulse one cycle with rsp_data = fpu_q; results return in issue order.
REQ-021 rsp_data SHALL be 32'h0 when no rsp_valid bit is high.
REQ-022 busy SHALL be the OR of all tag-pipeline valid bits.
REQ-023 flush high SHALL clear all tag-pipeline valid bits at the next edge, suppress gnt that cycle, and leave rr_ptr unchanged; no rsp_valid for discarded operations.
REQ-024 flush with all req low SHALL be harmless; flush for multiple cycles SHALL suppress grants throughout.

Reset
REQ-025 areset_n low SHALL immediately clear rr_ptr to 0, all tag valids, and force gnt, rsp_valid = 0, rsp_data = 0, busy = 0, lock state IDLE.
REQ-026 Reset mid-operation SHALL discard all in-flight results; no rsp_valid after release for pre-reset issues.

Configuration
REQ-027 With FPU_ARB_LOCK_EN defined, input lock (NREQ) SHALL exist and a two-state FSM IDLE/LOCKED SHALL be built.
REQ-028 IDLE -> LOCKED on grant to i with lock[i] high; in LOCKED only requester i SHALL be grantable; LOCKED -> IDLE when lock[i] low or flush; rr_ptr frozen while LOCKED and set to (i+1) mod NREQ on exit.
REQ-029 Without FPU_ARB_LOCK_EN, no lock port and no FSM; pure round-robin per REQ-015..016.

Structure
REQ-030 Package fpu_arb_pkg SHALL hold FP_W = 32, NREQ_MAX = 8, LAT_MAX = 16, typedef fp32_t, and the tag struct typedef {logic valid; logic [2:0] idx}.
REQ-031 Sub-module fpu_tag_pipe (LAT-deep tag shift register with flush and async clear) SHALL be instantiated once; round-robin pick stays in fpu_arbiter.

Verification
REQ-032 Single req[2], op_a=0x3F800000, op_b=0x40000000, bench fp_mul model LAT=5 -> gnt[2] same cycle, rsp_valid[2] exactly 5 cycles later, rsp_data=0x40000000.
REQ-033 All four req held high 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3, responses in same order, one per cycle.
REQ-034 req[1],req[3] high with rr_ptr=2 -> gnt[3] first, then gnt[1]; rr_ptr ends at 2.
REQ-035 Three issues back-to-back, flush pulsed 2 cycles after first -> no rsp_valid for any of the three, busy low the cycle after flush, next req granted normally.
REQ-036 areset_n pulsed low while 4 operations in flight -> all outputs 0 immediately, no rsp_valid after release, first grant goes to index 0.
REQ-037 FPU_ARB_LOCK_EN: req[0..3] high, lock[1] high 3 cycles -> gnt[1] 3 consecutive cycles, requesters 0/2/3 starved meanwhile, then gnt[2].
